// File: rtl/mem_arbiter.sv
// Shares one memory request/response port between instruction fetch and the data path.
// Define MEM_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES with ERR_CODE.
module mem_arbiter #(
   parameter int unsigned     ADDR_W         = 32,
   parameter int unsigned     WORD_W         = 32,
   parameter int unsigned     COUNT_W        = 2,
   parameter int unsigned     CODE_W         = 2,
   parameter int unsigned     STARVE_LIMIT   = 4,
   parameter int unsigned     TIMEOUT_CYCLES = 255,
   parameter logic [CODE_W-1:0] ERR_CODE     = 2'b11
) (
   input  logic               clk,
   input  logic               aresetn,
   input  logic               i_instr_req_en,
   input  logic [ADDR_W-1:0]  i_instr_req_addr,
   output logic               o_instr_res_valid,
   output logic [WORD_W-1:0]  o_instr_res_data,
   output logic               o_instr_stall,
   input  logic               i_data_req_en,
   input  logic [ADDR_W-1:0]  i_data_req_addr,
   input  logic [WORD_W-1:0]  i_data_req_wr_data,
   input  logic               i_data_req_wr_en,
   input  logic [COUNT_W-1:0] i_data_req_count,
   output logic               o_data_res_valid,
   output logic [WORD_W-1:0]  o_data_res_rd_data,
   output logic [CODE_W-1:0]  o_data_res_code,
   output logic               o_data_stall,
   output logic               o_mem_req_valid,
   input  logic               i_mem_req_ready,
   output logic [ADDR_W-1:0]  o_mem_req_addr,
   output logic [WORD_W-1:0]  o_mem_req_wr_data,
   output logic               o_mem_req_wr_en,
   output logic [COUNT_W-1:0] o_mem_req_count,
   input  logic               i_mem_res_valid,
   input  logic [WORD_W-1:0]  i_mem_res_rd_data,
   input  logic [CODE_W-1:0]  i_mem_res_code,
   output logic [1:0]         o_dbg_state
);

   // Handshake: o_mem_req_valid rises in REQ and its fields stay frozen until the cycle
   // i_mem_req_ready is sampled high; i_mem_res_valid is only honoured in WAIT.
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

   localparam int unsigned SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

   if (TIMEOUT_CYCLES < 1 || ERR_CODE == '0) begin : g_bad_cfg
      $error("mem_arbiter: TIMEOUT_CYCLES must be >= 1 and ERR_CODE must be nonzero");
   end

   state_e             state_q, state_d;
   logic               owner_q, owner_d;   // 1 = instruction fetch owns the port
   logic [SC_W-1:0]    starve_q, starve_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [WORD_W-1:0]  wr_data_q, wr_data_d;
   logic               wr_en_q, wr_en_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [WORD_W-1:0]  instr_data_q, instr_data_d;
   logic [WORD_W-1:0]  data_rd_q, data_rd_d;
   logic [CODE_W-1:0]  data_code_q, data_code_d;
   logic               instr_win;
   logic               tmo_hit;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TMO_W-1:0] tmo_q, tmo_d;

   assign tmo_hit = (state_q == S_WAIT) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      tmo_d = '0;
      if (state_q == S_WAIT) tmo_d = tmo_q + 1'b1;
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) tmo_q <= '0;
      else          tmo_q <= tmo_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Data has priority; a starved fetch wins once the data path has had its quota.
   assign instr_win = i_instr_req_en &&
                      (!i_data_req_en || ((STARVE_LIMIT != 0) && (starve_q == STARVE_MAX)));

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      starve_d     = starve_q;
      addr_d       = addr_q;
      wr_data_d    = wr_data_q;
      wr_en_d      = wr_en_q;
      count_d      = count_q;
      instr_data_d = instr_data_q;
      data_rd_d    = data_rd_q;
      data_code_d  = data_code_q;
      case (state_q)
         S_IDLE: begin
            if (instr_win) begin
               state_d   = S_REQ;
               owner_d   = 1'b1;
               starve_d  = '0;
               addr_d    = i_instr_req_addr;
               wr_data_d = '0;
               wr_en_d   = 1'b0;
               count_d   = '1;
            end else if (i_data_req_en) begin
               state_d   = S_REQ;
               owner_d   = 1'b0;
               addr_d    = i_data_req_addr;
               wr_data_d = i_data_req_wr_data;
               wr_en_d   = i_data_req_wr_en;
               count_d   = i_data_req_count;
               if (i_instr_req_en && (starve_q != STARVE_MAX)) starve_d = starve_q + 1'b1;
            end
         end
         S_REQ: begin
            if (i_mem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (i_mem_res_valid) begin
               state_d = S_RESP;
               if (owner_q) begin
                  instr_data_d = i_mem_res_rd_data;
               end else begin
                  data_rd_d   = i_mem_res_rd_data;
                  data_code_d = i_mem_res_code;
               end
            end else if (tmo_hit) begin
               state_d = S_RESP;
               if (owner_q) begin
                  instr_data_d = '0;
               end else begin
                  data_rd_d   = '0;
                  data_code_d = ERR_CODE;
               end
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         starve_q     <= '0;
         addr_q       <= '0;
         wr_data_q    <= '0;
         wr_en_q      <= 1'b0;
         count_q      <= '0;
         instr_data_q <= '0;
         data_rd_q    <= '0;
         data_code_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         starve_q     <= starve_d;
         addr_q       <= addr_d;
         wr_data_q    <= wr_data_d;
         wr_en_q      <= wr_en_d;
         count_q      <= count_d;
         instr_data_q <= instr_data_d;
         data_rd_q    <= data_rd_d;
         data_code_q  <= data_code_d;
      end
   end

   assign o_mem_req_valid    = (state_q == S_REQ);
   assign o_mem_req_addr     = addr_q;
   assign o_mem_req_wr_data  = wr_data_q;
   assign o_mem_req_wr_en    = wr_en_q;
   assign o_mem_req_count    = count_q;
   assign o_instr_res_valid  = (state_q == S_RESP) && owner_q;
   assign o_data_res_valid   = (state_q == S_RESP) && !owner_q;
   assign o_instr_res_data   = instr_data_q;
   assign o_data_res_rd_data = data_rd_q;
   assign o_data_res_code    = data_code_q;
   assign o_instr_stall      = i_instr_req_en & ~o_instr_res_valid;
   assign o_data_stall       = i_data_req_en & ~o_data_res_valid;
   assign o_dbg_state        = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, response scoreboard, scenario tasks.
// The timeout scenario runs only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic        i_instr_req_en, i_data_req_en, i_data_req_wr_en;
   logic [31:0] i_instr_req_addr, i_data_req_addr, i_data_req_wr_data;
   logic [1:0]  i_data_req_count;
   logic        o_instr_res_valid, o_instr_stall, o_data_res_valid, o_data_stall;
   logic [31:0] o_instr_res_data, o_data_res_rd_data;
   logic [1:0]  o_data_res_code;
   logic        o_mem_req_valid, i_mem_req_ready, o_mem_req_wr_en;
   logic [31:0] o_mem_req_addr, o_mem_req_wr_data;
   logic [1:0]  o_mem_req_count;
   logic        i_mem_res_valid;
   logic [31:0] i_mem_res_rd_data;
   logic [1:0]  i_mem_res_code;
   logic [1:0]  o_dbg_state;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .aresetn(aresetn),
      .i_instr_req_en(i_instr_req_en), .i_instr_req_addr(i_instr_req_addr),
      .o_instr_res_valid(o_instr_res_valid), .o_instr_res_data(o_instr_res_data),
      .o_instr_stall(o_instr_stall),
      .i_data_req_en(i_data_req_en), .i_data_req_addr(i_data_req_addr),
      .i_data_req_wr_data(i_data_req_wr_data), .i_data_req_wr_en(i_data_req_wr_en),
      .i_data_req_count(i_data_req_count),
      .o_data_res_valid(o_data_res_valid), .o_data_res_rd_data(o_data_res_rd_data),
      .o_data_res_code(o_data_res_code), .o_data_stall(o_data_stall),
      .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
      .o_mem_req_addr(o_mem_req_addr), .o_mem_req_wr_data(o_mem_req_wr_data),
      .o_mem_req_wr_en(o_mem_req_wr_en), .o_mem_req_count(o_mem_req_count),
      .i_mem_res_valid(i_mem_res_valid), .i_mem_res_rd_data(i_mem_res_rd_data),
      .i_mem_res_code(i_mem_res_code), .o_dbg_state(o_dbg_state)
   );

   // scoreboard entry: {instr_owner, data, code}; accepted request: {wr_en, count, addr, wr_data}
   logic [34:0] exp_q[$];
   logic [66:0] acc_log[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          stall_left = 0;
   bit          spurious = 1'b0;
   bit          no_resp = 1'b0;

   function automatic logic [31:0] rd_for(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEAD_BEEF : {~a[15:0], a[15:0]};
   endfunction

   function automatic logic [1:0] code_for(input logic [31:0] a);
      return a[3:2] ^ a[9:8];
   endfunction

   // memory model: accepts when not back-pressured, answers in the first WAIT cycle
   initial begin : mem_model
      logic        acc, busy;
      logic [31:0] acc_addr;
      acc = 1'b0; busy = 1'b0; acc_addr = '0;
      i_mem_req_ready = 1'b0; i_mem_res_valid = 1'b0;
      i_mem_res_rd_data = '0; i_mem_res_code = '0;
      forever begin
         @(negedge clk);
         i_mem_req_ready = 1'b0;
         i_mem_res_valid = 1'b0;
         if (!aresetn) begin
            acc = 1'b0; busy = 1'b0;
         end else begin
            if (acc) begin busy = 1'b1; acc = 1'b0; end
            if (busy && !no_resp) begin
               i_mem_res_valid   = 1'b1;
               i_mem_res_rd_data = rd_for(acc_addr);
               i_mem_res_code    = code_for(acc_addr);
               busy = 1'b0;
            end
            if (o_mem_req_valid) begin
               if (stall_left > 0) begin
                  stall_left--;
                  if (spurious) begin
                     i_mem_res_valid   = 1'b1;
                     i_mem_res_rd_data = 32'hBAD0_BAD0;
                     i_mem_res_code    = 2'b10;
                  end
               end else begin
                  i_mem_req_ready = 1'b1;
                  acc = 1'b1;
                  acc_addr = o_mem_req_addr;
                  acc_log.push_back({o_mem_req_wr_en, o_mem_req_count, o_mem_req_addr, o_mem_req_wr_data});
               end
            end
         end
      end
   end

   // response monitor: every res_valid pulse consumes one scoreboard entry
   always @(negedge clk) begin
      logic [34:0] got, exp;
      if (aresetn && (o_instr_res_valid || o_data_res_valid)) begin
         n_checks++;
         got = o_instr_res_valid ? {1'b1, o_instr_res_data, 2'b00}
                                 : {1'b0, o_data_res_rd_data, o_data_res_code};
         if (o_instr_res_valid && o_data_res_valid) begin
            n_errors++;
            $display("FAIL resp_both_valid: both res_valid high at %0t", $time);
         end else if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL resp_unexpected: got %h with nothing expected", got);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               n_errors++;
               $display("FAIL resp_data: got %h expected %h", got, exp);
            end
         end
      end
   end

   task automatic wait_resp(input bit is_instr, output int cyc);
      cyc = -1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (is_instr ? o_instr_res_valid : o_data_res_valid) begin
            cyc = c;
            return;
         end
      end
   endtask

   task automatic drive_data(input logic [31:0] a, input logic [31:0] wd, input logic we,
                             input logic [1:0] cnt);
      i_data_req_addr = a; i_data_req_wr_data = wd; i_data_req_wr_en = we;
      i_data_req_count = cnt; i_data_req_en = 1'b1;
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      i_instr_req_en = 1'b0; i_instr_req_addr = '0;
      i_data_req_en = 1'b0; i_data_req_addr = '0; i_data_req_wr_data = '0;
      i_data_req_wr_en = 1'b0; i_data_req_count = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (o_dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", o_dbg_state); end
      n_checks++;
      if ({o_mem_req_valid, o_mem_req_addr, o_mem_req_wr_data, o_mem_req_wr_en, o_mem_req_count} !== '0) begin
         n_errors++; $display("FAIL reset_mem_req: got nonzero request fields, expected 0");
      end
      n_checks++;
      if ({o_instr_res_valid, o_data_res_valid, o_instr_res_data, o_data_res_rd_data, o_data_res_code} !== '0) begin
         n_errors++; $display("FAIL reset_resp: got nonzero response outputs, expected 0");
      end
      aresetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_instr_only();
      int lat = -1;
      int stall_hi = 0;
      logic [66:0] a;
      i_instr_req_addr = 32'h100; i_instr_req_en = 1'b1;
      exp_q.push_back({1'b1, 32'hDEAD_BEEF, 2'b00});
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         if (o_instr_res_valid) begin lat = c; break; end
         if (o_instr_stall) stall_hi++;
      end
      n_checks++;
      if (lat != 3) begin n_errors++; $display("FAIL instr_latency: got %0d expected 3", lat); end
      n_checks++;
      if (stall_hi != 2 || o_instr_stall !== 1'b0) begin
         n_errors++; $display("FAIL instr_stall: got %0d stalled cycles (stall now %b) expected 2 and 0", stall_hi, o_instr_stall);
      end
      n_checks++;
      a = (acc_log.size() > 0) ? acc_log.pop_front() : '1;
      if (a !== {1'b0, 2'b11, 32'h100, 32'h0}) begin
         n_errors++; $display("FAIL instr_mem_fields: got %h expected %h", a, {1'b0, 2'b11, 32'h100, 32'h0});
      end
      @(negedge clk);
      i_instr_req_en = 1'b0;
      n_checks++;
      if (o_instr_res_data !== 32'hDEAD_BEEF) begin
         n_errors++; $display("FAIL instr_data_hold: got %h expected deadbeef", o_instr_res_data);
      end
   endtask

   task automatic test_both();
      int d_low = 0, i_low = 0, cyc = 0;
      bit d_drop = 0, i_drop = 0;
      logic [66:0] a;
      drive_data(32'h200, 32'h55, 1'b1, 2'd2);
      i_instr_req_addr = 32'h180; i_instr_req_en = 1'b1;
      exp_q.push_back({1'b0, rd_for(32'h200), code_for(32'h200)});
      exp_q.push_back({1'b1, rd_for(32'h180), 2'b00});
      while ((i_data_req_en || i_instr_req_en) && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (i_data_req_en && !o_data_stall) d_low++;
         if (i_instr_req_en && !o_instr_stall) i_low++;
         if (d_drop) begin i_data_req_en = 1'b0; d_drop = 0; end
         if (i_drop) begin i_instr_req_en = 1'b0; i_drop = 0; end
         if (o_data_res_valid) d_drop = 1;
         if (o_instr_res_valid) i_drop = 1;
      end
      i_data_req_en = 1'b0; i_instr_req_en = 1'b0;
      n_checks++;
      if (d_low != 1 || i_low != 1) begin
         n_errors++; $display("FAIL both_stalls: got data %0d instr %0d unstalled cycles expected 1 and 1", d_low, i_low);
      end
      n_checks++;
      a = (acc_log.size() > 0) ? acc_log.pop_front() : '1;
      if (a !== {1'b1, 2'd2, 32'h200, 32'h55}) begin
         n_errors++; $display("FAIL both_first_grant: got %h expected %h", a, {1'b1, 2'd2, 32'h200, 32'h55});
      end
      n_checks++;
      a = (acc_log.size() > 0) ? acc_log.pop_front() : '1;
      if (a !== {1'b0, 2'b11, 32'h180, 32'h0}) begin
         n_errors++; $display("FAIL both_second_grant: got %h expected %h", a, {1'b0, 2'b11, 32'h180, 32'h0});
      end
   endtask

   task automatic test_starvation();
      logic [31:0] order [6];
      int k = 0, done = 0, cyc = 0;
      bit d_upd = 0, i_drop = 0;
      logic [66:0] a;
      order = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h800, 32'h410};
      foreach (order[j])
         exp_q.push_back({order[j] == 32'h800, rd_for(order[j]),
                          (order[j] == 32'h800) ? 2'b00 : code_for(order[j])});
      drive_data(32'h400, 32'h0, 1'b0, 2'd2);
      i_instr_req_addr = 32'h800; i_instr_req_en = 1'b1;
      while (done < 6 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (i_drop) begin i_instr_req_en = 1'b0; i_drop = 0; end
         if (d_upd) begin
            k++;
            i_data_req_addr = 32'h400 + 32'(4 * k);
            if (k == 5) i_data_req_en = 1'b0;
            d_upd = 0;
         end
         if (o_instr_res_valid) begin i_drop = 1; done++; end
         if (o_data_res_valid) begin d_upd = 1; done++; end
      end
      @(negedge clk);
      i_instr_req_en = 1'b0; i_data_req_en = 1'b0;
      n_checks++;
      if (done != 6) begin n_errors++; $display("FAIL starve_timeout: got %0d responses expected 6", done); end
      foreach (order[j]) begin
         n_checks++;
         a = (acc_log.size() > 0) ? acc_log.pop_front() : '1;
         if (a[63:32] !== order[j]) begin
            n_errors++; $display("FAIL starve_grant_%0d: got addr %h expected %h", j, a[63:32], order[j]);
         end
      end
   endtask

   task automatic test_backpressure();
      int vcyc = 0, bad = 0, lat;
      logic [66:0] exp_f;
      exp_f = {1'b0, 2'd1, 32'h500, 32'h77};
      stall_left = 5; spurious = 1'b1;
      drive_data(32'h500, 32'h77, 1'b0, 2'd1);
      exp_q.push_back({1'b0, rd_for(32'h500), code_for(32'h500)});
      lat = -1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (o_data_res_valid) begin lat = c; break; end
         if (o_mem_req_valid) begin
            vcyc++;
            if ({o_mem_req_wr_en, o_mem_req_count, o_mem_req_addr, o_mem_req_wr_data} !== exp_f) bad++;
         end
      end
      spurious = 1'b0;
      @(negedge clk);
      i_data_req_en = 1'b0;
      n_checks++;
      if (vcyc != 6 || bad != 0 || lat != 8) begin
         n_errors++; $display("FAIL bp_hold: got %0d valid cycles, %0d unstable, latency %0d expected 6, 0, 8", vcyc, bad, lat);
      end
      void'(acc_log.pop_front());
   endtask

   task automatic test_reset_mid_wait();
      int lat;
      no_resp = 1'b1;
      drive_data(32'h600, 32'h99, 1'b1, 2'd3);
      for (int c = 0; c < 20 && acc_log.size() == 0; c++) @(negedge clk);
      void'(acc_log.pop_front());
      repeat (2) @(negedge clk);
      n_checks++;
      if (o_dbg_state !== 2'd2) begin n_errors++; $display("FAIL mid_wait_state: got %0d expected 2", o_dbg_state); end
      #1 aresetn = 1'b0;
      #1;
      n_checks++;
      if ({o_mem_req_valid, o_mem_req_addr, o_mem_req_wr_data, o_mem_req_wr_en, o_mem_req_count,
           o_instr_res_valid, o_data_res_valid, o_instr_res_data, o_data_res_rd_data,
           o_data_res_code, o_dbg_state} !== '0) begin
         n_errors++; $display("FAIL async_reset_clear: outputs nonzero (addr %h idata %h ddata %h) expected all 0",
                              o_mem_req_addr, o_instr_res_data, o_data_res_rd_data);
      end
      i_data_req_en = 1'b0;
      no_resp = 1'b0;
      repeat (2) @(negedge clk);
      aresetn = 1'b1;
      @(negedge clk);
      drive_data(32'h44, 32'h0, 1'b0, 2'd2);
      exp_q.push_back({1'b0, rd_for(32'h44), 2'b01});
      wait_resp(1'b0, lat);
      n_checks++;
      if (lat != 3 || o_data_res_code !== 2'b01) begin
         n_errors++; $display("FAIL post_reset_txn: got latency %0d code %b expected 3 and 01", lat, o_data_res_code);
      end
      @(negedge clk);
      i_data_req_en = 1'b0;
      void'(acc_log.pop_front());
   endtask

`ifdef MEM_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int lat;
      no_resp = 1'b1;
      drive_data(32'h700, 32'h0, 1'b0, 2'd2);
      exp_q.push_back({1'b0, 32'h0, 2'b11});
      for (int c = 0; c < 20 && acc_log.size() == 0; c++) @(negedge clk);
      wait_resp(1'b0, lat);
      n_checks++;
      if (lat != 9 || o_data_res_rd_data !== 32'h0 || o_data_res_code !== 2'b11) begin
         n_errors++; $display("FAIL timeout_resp: got latency %0d data %h code %b expected 9, 0, 11",
                              lat, o_data_res_rd_data, o_data_res_code);
      end
      @(negedge clk);
      i_data_req_en = 1'b0;
      no_resp = 1'b0;
      void'(acc_log.pop_front());
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_instr_only();
      test_both();
      test_starvation();
      test_backpressure();
      test_reset_mid_wait();
`ifdef MEM_ARB_TIMEOUT_EN
      test_timeout();
`endif
      repeat (4) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++; $display("FAIL scoreboard_drain: got %0d pending entries expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
